mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit of the 5-stage MIPS core.
- Sits between the EX/MEM pipeline register and MEM_WB.
- Issues loads and stores to the data RAM over a ready-handshake bus and stalls the pipeline while an access is outstanding.
- Aligns and extends load data, builds store byte strobes, and passes register and HI/LO write-back fields through to MEM_WB.

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues loads/stores over a ready-handshake bus, stalls
// the pipeline while an access is outstanding. Define MEM_ADDR_CHECK_EN to trap misaligned accesses.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_in,
   input  logic                  mem_read_en,
   input  logic                  mem_write_en,
   input  logic [1:0]            mem_size,
   input  logic                  mem_sign_ext,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] result_in,
   input  logic                  write_reg_en_in,
   input  logic [4:0]            write_reg_addr_in,
   input  logic                  write_hilo_en_in,
   input  logic [DATA_WIDTH-1:0] write_hi_data_in,
   input  logic [DATA_WIDTH-1:0] write_lo_data_in,
   output logic                  ram_en,
   output logic [3:0]            ram_write_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   input  logic                  ram_ready,
   input  logic [DATA_WIDTH-1:0] ram_read_data,
   output logic                  stall_request,
`ifdef MEM_ADDR_CHECK_EN
   output logic                  addr_error,
`endif
   output logic [DATA_WIDTH-1:0] result_out,
   output logic                  write_reg_en_out,
   output logic [4:0]            write_reg_addr_out,
   output logic                  write_hilo_en_out,
   output logic [DATA_WIDTH-1:0] write_hi_data_out,
   output logic [DATA_WIDTH-1:0] write_lo_data_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [DATA_WIDTH-1:0]  load_buf_q;
   logic [DATA_WIDTH-1:0]  load_buf_d;

   logic                   mem_op;
   logic                   is_store;
   logic                   size_byte;
   logic                   size_half;
   logic                   misaligned;
   logic                   access_go;

   logic [3:0]             strobe;
   logic [DATA_WIDTH-1:0]  lane_wdata;
   logic [7:0]             buf_byte [4];
   logic [15:0]            buf_half [2];
   logic [7:0]             sel_byte;
   logic [15:0]            sel_half;
   logic [DATA_WIDTH-1:0]  load_aligned;

   assign mem_op    = mem_read_en | mem_write_en;
   assign is_store  = mem_write_en & ~mem_read_en;
   assign size_byte = (mem_size == 2'd0);
   assign size_half = (mem_size == 2'd1);

`ifdef MEM_ADDR_CHECK_EN
   assign misaligned = (size_half & mem_addr[0]) |
                       (~size_byte & ~size_half & (mem_addr[1:0] != 2'b00));
   assign addr_error = mem_op & misaligned;
`else
   assign misaligned = 1'b0;
`endif

   assign access_go = mem_op & ~misaligned;

   // Per-lane store strobes, replicated store data and load-buffer byte views.
   // Half accesses select lanes by addr[1] only, so addr[0] never shifts a halfword.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign strobe[gi] = size_byte ? (mem_addr[1:0] == 2'(gi)) :
                             size_half ? (mem_addr[1] == 1'(gi / 2)) :
                                         1'b1;
         assign lane_wdata[8*gi +: 8] = size_byte ? mem_write_data[7:0] :
                                        size_half ? mem_write_data[8*(gi % 2) +: 8] :
                                                    mem_write_data[8*gi +: 8];
         assign buf_byte[gi] = load_buf_q[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign buf_half[gi] = load_buf_q[16*gi +: 16];
      end
   endgenerate

   always_comb begin
      sel_byte     = buf_byte[mem_addr[1:0]];
      sel_half     = buf_half[mem_addr[1]];
      load_aligned = load_buf_q;
      if (size_byte) begin
         load_aligned = {{(DATA_WIDTH-8){mem_sign_ext & sel_byte[7]}}, sel_byte};
      end else if (size_half) begin
         load_aligned = {{(DATA_WIDTH-16){mem_sign_ext & sel_half[15]}}, sel_half};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         load_buf_q <= '0;
      end else begin
         state_q    <= state_d;
         load_buf_q <= load_buf_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      load_buf_d    = load_buf_q;
      ram_en        = 1'b0;
      stall_request = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (access_go) begin
               stall_request = 1'b1;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            ram_en        = 1'b1;
            stall_request = 1'b1;
            if (ram_ready) begin
               load_buf_d = ram_read_data;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            // Hold here while the stage is frozen externally; the access is never re-issued.
            if (!stall_in) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The EX/MEM register is frozen during WAIT, so bus fields stay stable straight from the inputs.
   assign ram_addr       = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
   assign ram_write_data = lane_wdata;
   assign ram_write_en   = ((state_q == ST_WAIT) && is_store) ? strobe : 4'b0000;

   assign result_out = mem_read_en ? load_aligned : result_in;

`ifdef MEM_ADDR_CHECK_EN
   assign write_reg_en_out = write_reg_en_in & ~(mem_op & misaligned);
`else
   assign write_reg_en_out = write_reg_en_in;
`endif
   assign write_reg_addr_out = write_reg_addr_in;
   assign write_hilo_en_out  = write_hilo_en_in;
   assign write_hi_data_out  = write_hi_data_in;
   assign write_lo_data_out  = write_lo_data_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: per-instruction timeline model plus directed
// literal cases, then randomized loads/stores/ALU ops with random bus latency and MEM holds.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [1:0]  mem_size;
   logic        mem_sign_ext;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] result_in;
   logic        write_reg_en_in;
   logic [4:0]  write_reg_addr_in;
   logic        write_hilo_en_in;
   logic [31:0] write_hi_data_in;
   logic [31:0] write_lo_data_in;
   logic        ram_en;
   logic [3:0]  ram_write_en;
   logic [31:0] ram_addr;
   logic [31:0] ram_write_data;
   logic        ram_ready;
   logic [31:0] ram_read_data;
   logic        stall_request;
   logic [31:0] result_out;
   logic        write_reg_en_out;
   logic [4:0]  write_reg_addr_out;
   logic        write_hilo_en_out;
   logic [31:0] write_hi_data_out;
   logic [31:0] write_lo_data_out;
`ifdef MEM_ADDR_CHECK_EN
   logic        addr_error;
`endif

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_size(mem_size), .mem_sign_ext(mem_sign_ext),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .result_in(result_in), .write_reg_en_in(write_reg_en_in),
      .write_reg_addr_in(write_reg_addr_in), .write_hilo_en_in(write_hilo_en_in),
      .write_hi_data_in(write_hi_data_in), .write_lo_data_in(write_lo_data_in),
      .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
      .ram_write_data(ram_write_data), .ram_ready(ram_ready),
      .ram_read_data(ram_read_data), .stall_request(stall_request),
`ifdef MEM_ADDR_CHECK_EN
      .addr_error(addr_error),
`endif
      .result_out(result_out), .write_reg_en_out(write_reg_en_out),
      .write_reg_addr_out(write_reg_addr_out), .write_hilo_en_out(write_hilo_en_out),
      .write_hi_data_out(write_hi_data_out), .write_lo_data_out(write_lo_data_out)
   );

   always #5 clk = ~clk;

   // Expected per-cycle behaviour, set by the driver just after each rising edge.
   bit          chk_on = 1'b0;
   bit          exp_stall, exp_en, exp_res_chk, exp_wd_chk, exp_force_wr0, exp_addr_err;
   logic [3:0]  exp_we;
   logic [31:0] exp_addr, exp_wd, exp_res;
   bit          pin_res_en, pin_bus_en, pin_cnt_en, win_clear;
   logic [31:0] pin_res, pin_wd, pin_addr;
   logic [3:0]  pin_we;
   int          pin_en_cnt, pin_stall_cnt, pin_acc_cnt;

   int          checks = 0;
   int          errors = 0;
   int          en_cnt = 0, stall_cnt = 0, acc_cnt = 0;
   bit          prev_en = 1'b0;

   function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sx,
                                          input logic [31:0] a, input logic [31:0] d);
      logic [31:0] v;
      logic [1:0]  lo;
      lo = a[1:0];
      if (sz == 2'd0) begin
         v = (d >> (32'(lo) * 8)) & 32'h0000_00FF;
         if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (d >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
         if (sx && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic [3:0] m_strobe(input logic [1:0] sz, input logic [31:0] a);
      logic [1:0] lo;
      lo = a[1:0];
      if (sz == 2'd0) return 4'b0001 << lo;
      if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return (wd & 32'h0000_00FF) * 32'h0101_0101;
      if (sz == 2'd1) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
      if (sz == 2'd1) return a[0];
      if (sz != 2'd0) return a[1:0] != 2'b00;
      return 1'b0;
`else
      return (sz == 2'd3) && (a == 32'h1) && (a != 32'h1);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: checks every cycle while chk_on is set.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            if (pin_cnt_en) begin
               chk("cnt_ram_en_cycles", 32'(en_cnt), 32'(pin_en_cnt));
               chk("cnt_stall_cycles", 32'(stall_cnt), 32'(pin_stall_cnt));
               chk("cnt_bus_accesses", 32'(acc_cnt), 32'(pin_acc_cnt));
            end
            if (win_clear) begin
               en_cnt = 0;
               stall_cnt = 0;
               acc_cnt = 0;
            end
            if (ram_en === 1'b1) en_cnt++;
            if (stall_request === 1'b1) stall_cnt++;
            if (ram_en === 1'b1 && !prev_en) acc_cnt++;
            prev_en = (ram_en === 1'b1);

            chk("stall_request", 32'(stall_request), 32'(exp_stall));
            chk("ram_en", 32'(ram_en), 32'(exp_en));
            if (exp_en) begin
               chk("ram_addr", ram_addr, exp_addr);
               chk("ram_write_en", 32'(ram_write_en), 32'(exp_we));
               if (exp_wd_chk) chk("ram_write_data", ram_write_data, exp_wd);
            end
            if (exp_res_chk) chk("result_out", result_out, exp_res);
            chk("write_reg_en_out", 32'(write_reg_en_out),
                32'(write_reg_en_in & ~exp_force_wr0));
            chk("write_reg_addr_out", 32'(write_reg_addr_out), 32'(write_reg_addr_in));
            chk("write_hilo_en_out", 32'(write_hilo_en_out), 32'(write_hilo_en_in));
            chk("write_hi_data_out", write_hi_data_out, write_hi_data_in);
            chk("write_lo_data_out", write_lo_data_out, write_lo_data_in);
`ifdef MEM_ADDR_CHECK_EN
            chk("addr_error", 32'(addr_error), 32'(exp_addr_err));
`endif
            if (pin_res_en) chk("pin_result", result_out, pin_res);
            if (pin_bus_en) begin
               chk("pin_write_en", 32'(ram_write_en), 32'(pin_we));
               chk("pin_write_data", ram_write_data, pin_wd);
               chk("pin_addr", ram_addr, pin_addr);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      pin_res_en = 1'b0;
      pin_bus_en = 1'b0;
      pin_cnt_en = 1'b0;
      win_clear = 1'b0;
      ram_ready = 1'b0;
      ram_read_data = $urandom;
   endtask

   task automatic rand_fields();
      result_in = $urandom;
      write_reg_en_in = 1'($urandom_range(0, 1));
      write_reg_addr_in = 5'($urandom_range(0, 31));
      write_hilo_en_in = 1'($urandom_range(0, 1));
      write_hi_data_in = $urandom;
      write_lo_data_in = $urandom;
      exp_force_wr0 = 1'b0;
      exp_addr_err = 1'b0;
      exp_wd_chk = 1'b0;
   endtask

   task automatic run_alu(input logic [31:0] res, input bit pr_en,
                          input bit cnt_en, input int e_cnt, input int s_cnt, input int a_cnt);
      rand_fields();
      result_in = res;
      mem_read_en = 1'b0;
      mem_write_en = 1'b0;
      mem_size = 2'($urandom_range(0, 3));
      mem_sign_ext = 1'($urandom_range(0, 1));
      mem_addr = $urandom;
      mem_write_data = $urandom;
      stall_in = 1'b0;
      ram_ready = 1'($urandom_range(0, 1));
      exp_stall = 1'b0;
      exp_en = 1'b0;
      exp_res_chk = 1'b1;
      exp_res = res;
      pin_res_en = pr_en;
      pin_res = res;
      pin_cnt_en = cnt_en;
      pin_en_cnt = e_cnt;
      pin_stall_cnt = s_cnt;
      pin_acc_cnt = a_cnt;
      $display("op ALU result=%h", res);
      step();
   endtask

   task automatic run_mem(input bit ld, input logic [1:0] sz, input bit sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int nw, input int nh,
                          input bit pr_en, input logic [31:0] pr_val,
                          input bit pb_en, input logic [3:0] pb_we,
                          input logic [31:0] pb_wd, input logic [31:0] pb_addr);
      rand_fields();
      mem_read_en = ld;
      mem_write_en = !ld;
      mem_size = sz;
      mem_sign_ext = sx;
      mem_addr = addr;
      mem_write_data = wd;
      stall_in = 1'b0;
      win_clear = 1'b1;
      $display("op %s size=%0d sx=%0d addr=%h wd=%h rdata=%h wait=%0d hold=%0d",
               ld ? "LOAD" : "STORE", sz, sx, addr, wd, rdata, nw, nh);
      if (m_misaligned(sz, addr)) begin
         exp_stall = 1'b0;
         exp_en = 1'b0;
         exp_res_chk = 1'b0;
         exp_force_wr0 = 1'b1;
         exp_addr_err = 1'b1;
         ram_ready = 1'($urandom_range(0, 1));
         step();
         exp_force_wr0 = 1'b0;
         exp_addr_err = 1'b0;
      end else begin
         // Issue cycle: stall raised, bus not yet requested; stray ready is ignored.
         exp_stall = 1'b1;
         exp_en = 1'b0;
         exp_res_chk = !ld;
         exp_res = result_in;
         ram_ready = 1'($urandom_range(0, 1));
         step();
         for (int i = 1; i <= nw; i++) begin
            exp_stall = 1'b1;
            exp_en = 1'b1;
            exp_addr = {addr[31:2], 2'b00};
            exp_we = ld ? 4'b0000 : m_strobe(sz, addr);
            exp_wd_chk = !ld;
            exp_wd = m_wdata(sz, wd);
            exp_res_chk = !ld;
            ram_ready = (i == nw);
            if (i == nw) ram_read_data = rdata;
            pin_bus_en = pb_en;
            pin_we = pb_we;
            pin_wd = pb_wd;
            pin_addr = pb_addr;
            step();
         end
         for (int h = 0; h <= nh; h++) begin
            exp_stall = 1'b0;
            exp_en = 1'b0;
            exp_wd_chk = 1'b0;
            exp_res_chk = 1'b1;
            exp_res = ld ? m_load(sz, sx, addr, rdata) : result_in;
            stall_in = (h < nh);
            ram_ready = 1'($urandom_range(0, 1));
            pin_res_en = pr_en;
            pin_res = pr_val;
            step();
         end
         stall_in = 1'b0;
      end
   endtask

   task automatic run_reset_mid_wait();
      rand_fields();
      mem_read_en = 1'b1;
      mem_write_en = 1'b0;
      mem_size = 2'd2;
      mem_sign_ext = 1'b0;
      mem_addr = 32'h0000_0400;
      mem_write_data = $urandom;
      stall_in = 1'b0;
      win_clear = 1'b1;
      exp_stall = 1'b1;
      exp_en = 1'b0;
      exp_res_chk = 1'b0;
      $display("op RESET-IN-WAIT addr=%h", mem_addr);
      step();
      exp_en = 1'b1;
      exp_addr = 32'h0000_0400;
      exp_we = 4'b0000;
      step();
      chk_on = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_on = 1'b1;
      mem_read_en = 1'b0;
      exp_stall = 1'b0;
      exp_en = 1'b0;
      exp_res_chk = 1'b1;
      exp_res = result_in;
      ram_ready = 1'b1;
      step();
      // Window covered issue + one WAIT cycle only; the late ready must not restart anything.
      run_alu($urandom, 1'b0, 1'b1, 1, 2, 1);
   endtask

   initial begin
      rst = 1'b1;
      stall_in = 1'b0;
      mem_read_en = 1'b0;
      mem_write_en = 1'b0;
      mem_size = 2'd0;
      mem_sign_ext = 1'b0;
      mem_addr = '0;
      mem_write_data = '0;
      ram_ready = 1'b0;
      ram_read_data = '0;
      rand_fields();
      exp_stall = 1'b0;
      exp_en = 1'b0;
      exp_res_chk = 1'b1;
      exp_res = result_in;
      exp_we = '0;
      exp_addr = '0;
      exp_wd = '0;
      pin_res_en = 1'b0;
      pin_bus_en = 1'b0;
      pin_cnt_en = 1'b0;
      win_clear = 1'b0;
      pin_res = '0;
      pin_wd = '0;
      pin_addr = '0;
      pin_we = '0;
      pin_en_cnt = 0;
      pin_stall_cnt = 0;
      pin_acc_cnt = 0;
      step();

      // Reset state: no request, no stall, ALU result passes through.
      chk_on = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rand_fields();
         ram_ready = 1'b1;
         exp_res = result_in;
         $display("op RESET result_in=%h", result_in);
         step();
      end
      rst = 1'b0;

      // LW 0x100, ready after two WAIT cycles.
      run_mem(1'b1, 2'd2, 1'b0, 32'h0000_0100, $urandom, 32'hDEAD_BEEF, 2, 0,
              1'b1, 32'hDEAD_BEEF, 1'b0, 4'b0, 32'h0, 32'h0);
      run_alu($urandom, 1'b0, 1'b1, 2, 3, 1);
      // LB / LBU at 0x103.
      run_mem(1'b1, 2'd0, 1'b1, 32'h0000_0103, $urandom, 32'h80AA_BBCC, 1, 0,
              1'b1, 32'hFFFF_FF80, 1'b0, 4'b0, 32'h0, 32'h0);
      run_mem(1'b1, 2'd0, 1'b0, 32'h0000_0103, $urandom, 32'h80AA_BBCC, 1, 0,
              1'b1, 32'h0000_0080, 1'b0, 4'b0, 32'h0, 32'h0);
      // SH 0x202.
      run_mem(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_1234, $urandom, 2, 0,
              1'b0, 32'h0, 1'b1, 4'b1100, 32'h1234_1234, 32'h0000_0200);
      // ADD: same-cycle pass-through.
      run_alu(32'd5, 1'b1, 1'b0, 0, 0, 0);
      // External hold in DONE for two cycles: single bus access, stable result.
      run_mem(1'b1, 2'd2, 1'b0, 32'h0000_0300, $urandom, 32'h1357_9BDF, 1, 2,
              1'b1, 32'h1357_9BDF, 1'b0, 4'b0, 32'h0, 32'h0);
      run_alu($urandom, 1'b0, 1'b1, 1, 2, 1);
      // Reset while WAITing, then a late ready.
      run_reset_mid_wait();

      for (int n = 0; n < 200; n++) begin
         int kind;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            run_alu($urandom, 1'b0, 1'b0, 0, 0, 0);
         end else begin
            run_mem(kind != 3, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 2),
                    1'b0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
         end
      end

      chk_on = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
